// File: rtl/reversible_gate_pipe.sv
// reversible_gate_pipe
//   Applies one of four 3-input reversible gates (CNOT, Toffoli, Fredkin, Peres)
//   bitwise across WIDTH lanes, then carries the result through STAGES register
//   stages with valid/ready flow control. The gate is evaluated in front of the
//   stage-1 register; every later stage is a pure delay. done_cnt counts output
//   handshakes and wraps.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready  input handshake
//   mode, inv           gate select (0 CNOT, 1 Toffoli, 2 Fredkin, 3 Peres), inverse flag
//   a, b, c             control vector and the two data vectors
//   out_valid, out_ready output handshake
//   p, q, r, out_mode   gate outputs and the mode carried with them
//   done_cnt            completed output handshakes, modulo 2^CNT_W
module reversible_gate_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic             inv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] done_cnt
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  p_q    [STAGES];
    logic [WIDTH-1:0]  q_q    [STAGES];
    logic [WIDTH-1:0]  r_q    [STAGES];
    logic [1:0]        mode_q [STAGES];
    logic [CNT_W-1:0]  cnt_q;

    logic [WIDTH-1:0]  g_p;
    logic [WIDTH-1:0]  g_q;
    logic [WIDTH-1:0]  g_r;

    // Gate evaluation, bitwise across all lanes.
    always_comb begin
        g_p = a;
        g_q = b;
        g_r = c;
        case (mode)
            2'd0: g_q = a ^ b;
            2'd1: g_r = (a & b) ^ c;
            2'd2: begin
                // Controlled swap of b and c.
                g_q = (a & c) | (~a & b);
                g_r = (a & b) | (~a & c);
            end
            2'd3: begin
                g_q = a ^ b;
                // Inverse Peres uses the freshly computed q (a & (a^b) == a & ~b).
                g_r = inv ? ((a & ~b) ^ c) : ((a & b) ^ c);
            end
        endcase
    end

    // Stage k may load iff some stage at or after k is empty, or the output is
    // being drained. Written in closed form so there is no combinational chain
    // through the load vector itself.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int unsigned j = 0; j < STAGES; j++) begin
                if (j >= k && !vld_q[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                p_q[k]    <= '0;
                q_q[k]    <= '0;
                r_q[k]    <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld_q[0]  <= in_valid;
                p_q[0]    <= g_p;
                q_q[0]    <= g_q;
                r_q[0]    <= g_r;
                mode_q[0] <= mode;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld_q[k]  <= vld_q[k-1];
                    p_q[k]    <= p_q[k-1];
                    q_q[k]    <= q_q[k-1];
                    r_q[k]    <= r_q[k-1];
                    mode_q[k] <= mode_q[k-1];
                end
            end
            if (vld_q[STAGES-1] && out_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[STAGES-1];
    assign p         = p_q[STAGES-1];
    assign q         = q_q[STAGES-1];
    assign r         = r_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_reversible_gate_pipe.sv
// Testbench for reversible_gate_pipe: a per-bit reference model plus a FIFO
// scoreboard checked every cycle, with a few hand-computed literal expectations.
module tb_reversible_gate_pipe;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic          inv;
    logic [W-1:0]  a, b, c;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  p, q, r;
    logic [1:0]    out_mode;
    logic [CW-1:0] done_cnt;

    reversible_gate_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .inv       (inv),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .q         (q),
        .r         (r),
        .out_mode  (out_mode),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference gate, one lane at a time.
    function automatic logic [3*W-1:0] ref_gate(input logic [1:0] m, input logic iv,
                                                input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [W-1:0] z);
        logic [W-1:0] op, oq, orr;
        for (int i = 0; i < W; i++) begin
            op[i]  = x[i];
            oq[i]  = y[i];
            orr[i] = z[i];
            if (m == 2'd0) begin
                oq[i] = x[i] ^ y[i];
            end else if (m == 2'd1) begin
                orr[i] = z[i] ^ (x[i] & y[i]);
            end else if (m == 2'd2) begin
                if (x[i]) begin
                    oq[i]  = z[i];
                    orr[i] = y[i];
                end
            end else begin
                oq[i]  = x[i] ^ y[i];
                orr[i] = z[i] ^ (x[i] & (iv ? oq[i] : y[i]));
            end
        end
        return {op, oq, orr};
    endfunction

    typedef struct {
        logic [W-1:0] p, q, r;
        logic [1:0]   m;
        int           t;   // first edge count at which it may be at the output
    } item_t;

    item_t        mq[$];
    int           cyc = 0;
    int           m_cnt = 0;
    bit           prev_stall = 0;
    logic [W-1:0] hp, hq, hr;
    logic [1:0]   hm;
    int           or_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: runs on every falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        bit exp_v;
        item_t it;
        logic [3*W-1:0] g;
        if (rst) begin
            mq.delete();
            m_cnt      = 0;
            prev_stall = 0;
        end else begin
            exp_v = 0;
            if (mq.size() > 0) exp_v = (cyc >= mq[0].t);
            chk("out_valid", out_valid, exp_v);
            chk("in_ready", in_ready, (mq.size() < S) || out_ready);
            chk("done_cnt", done_cnt, m_cnt[CW-1:0]);
            if (exp_v && out_valid) begin
                chk("p", p, mq[0].p);
                chk("q", q, mq[0].q);
                chk("r", r, mq[0].r);
                chk("out_mode", out_mode, mq[0].m);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_p", p, hp);
                chk("stall_q", q, hq);
                chk("stall_r", r, hr);
                chk("stall_mode", out_mode, hm);
            end
            prev_stall = out_valid && !out_ready;
            hp = p; hq = q; hr = r; hm = out_mode;
            if (out_valid && out_ready && mq.size() > 0) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (in_valid && in_ready) begin
                g    = ref_gate(mode, inv, a, b, c);
                it.p = g[3*W-1:2*W];
                it.q = g[2*W-1:W];
                it.r = g[W-1:0];
                it.m = mode;
                it.t = cyc + S;
                mq.push_back(it);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [1:0] m, input logic iv, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] z);
        int guard = 0;
        bit ok;
        mode = m; inv = iv; a = x; b = y; c = z; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 200);
        chk("send_accept", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [W-1:0] xp, output logic [W-1:0] xq,
                            output logic [W-1:0] xr);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        chk("out_seen", out_valid, 1'b1);
        xp = p; xq = q; xr = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (mq.size() > 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_empty", mq.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int           lat;
    logic [W-1:0] xp, xq, xr;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 2'd0; inv = 1'b0;
        a = '0; b = '0; c = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done_cnt", done_cnt, 0);
        @(posedge clk);
        #1;

        // CNOT with exact two-cycle latency and a one-cycle valid pulse.
        send(2'd0, 1'b0, 8'hF0, 8'hAA, 8'h55);
        wait_out(lat, xp, xq, xr);
        chk("cnot_latency", lat, S);
        chk("cnot_p", xp, 8'hF0);
        chk("cnot_q", xq, 8'h5A);
        chk("cnot_r", xr, 8'h55);
        chk("cnot_pulse", out_valid, 1'b0);
        chk("cnot_cnt", done_cnt, 1);

        // Toffoli: r = (CC & AA) ^ F0 = 88 ^ F0.
        send(2'd1, 1'b0, 8'hCC, 8'hAA, 8'hF0);
        wait_out(lat, xp, xq, xr);
        chk("toff_p", xp, 8'hCC);
        chk("toff_q", xq, 8'hAA);
        chk("toff_r", xr, 8'h78);
        // Fredkin: lanes where a=1 swap b and c.
        send(2'd2, 1'b0, 8'hCC, 8'hAA, 8'hF0);
        wait_out(lat, xp, xq, xr);
        chk("fred_p", xp, 8'hCC);
        chk("fred_q", xq, 8'hE2);
        chk("fred_r", xr, 8'hB8);

        // Peres forward then inverse.
        send(2'd3, 1'b0, 8'h3C, 8'h0F, 8'h81);
        wait_out(lat, xp, xq, xr);
        chk("peres_q", xq, 8'h33);
        chk("peres_r", xr, 8'h8D);
        send(2'd3, 1'b1, xp, xq, xr);
        wait_out(lat, xp, xq, xr);
        chk("peres_inv_a", xp, 8'h3C);
        chk("peres_inv_b", xq, 8'h0F);
        chk("peres_inv_c", xr, 8'h81);
        chk("cnt_5", done_cnt, 5);

        // Fill the pipeline under full back-pressure, then reset between edges.
        or_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(2'd1, 1'b0, 8'h11, 8'h22, 8'h33);
        send(2'd2, 1'b0, 8'h44, 8'h55, 8'h66);
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_p", p, 0);
        chk("arst_q", q, 0);
        chk("arst_r", r, 0);
        chk("arst_mode", out_mode, 0);
        chk("arst_cnt", done_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        or_mode = 0;
        @(negedge clk);
        chk("arst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Ten back-to-back transactions under random back-pressure.
        or_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), W'($urandom),
                 W'($urandom), W'($urandom));
        end
        drain();
        chk("bp_cnt", done_cnt, 10);

        // Random traffic with idle gaps.
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), W'($urandom),
                 W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Counter wrap with a 4-bit counter.
        or_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 15; i++) send(2'd0, 1'b0, W'(i), W'(i * 3), W'(i * 7));
        drain();
        chk("wrap_15", done_cnt, 15);
        send(2'd1, 1'b0, 8'h01, 8'h02, 8'h03);
        drain();
        chk("wrap_0", done_cnt, 0);
        send(2'd3, 1'b1, 8'h04, 8'h05, 8'h06);
        drain();
        chk("wrap_1", done_cnt, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
